// File: rtl/vrf_writeback_sequencer_pkg.sv
// Shared types and helpers for the VRF write-back path.
package vrf_pkg;

  // Sequencer phases: IDLE waits for an instruction, ACTIVE accepts ALU results,
  // DRAIN empties the result buffer, DONE raises the completion pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } wb_state_t;

  // Width of the LMUL field; register group size is 1 << vmul.
  localparam int VMUL_W = 2;

  // Elements per architectural vector register (32 registers share the BRAM).
  function automatic int elem_per_reg(input int vector_length);
    return vector_length / 32;
  endfunction

endpackage

// File: rtl/vrf_writeback_sequencer_sync_fifo.sv
// Synchronous FIFO with registered full/empty and simultaneous push/pop.
// Push while full and pop while empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    count_nxt = count + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents need no reset because the flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vrf_writeback_sequencer.sv
// Collects ALU results for one vector instruction and streams them into the
// VRF BRAM write port for destination register vd, with a small result buffer
// absorbing write-port stalls.
module vrf_writeback_sequencer
  import vrf_pkg::*;
#(
  parameter int VECTOR_LENGTH = 1024,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  localparam int AW = $clog2(VECTOR_LENGTH),
  localparam int LW = $clog2(VECTOR_LENGTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [4:0]            vd_address_i,
  input  logic [VMUL_W-1:0]     vmul_i,
  input  logic [LW-1:0]         vector_length_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_mask_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic                  BRAM_w_stall_i,
  output logic [AW-1:0]         BRAM_w_address_o,
  output logic [DATA_WIDTH-1:0] BRAM_wdata_o,
  output logic                  BRAM_we_o,
  output logic                  ready_o,
  output logic                  done_o
);

  localparam int ELEM_PER_REG = elem_per_reg(VECTOR_LENGTH);

  typedef struct packed {
    logic [LW-1:0]         idx;
    logic                  mask;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Oversized lengths saturate to the size of the register group.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] req,
                                            input logic [VMUL_W-1:0] vmul);
    logic [LW-1:0] cap;
    cap = LW'(ELEM_PER_REG) << vmul;
    return (req > cap) ? cap : req;
  endfunction

  function automatic logic [AW-1:0] reg_base(input logic [4:0] vd);
    return AW'(vd) * AW'(ELEM_PER_REG);
  endfunction

  // Address arithmetic is modulo the BRAM depth, so groups wrap past v31.
  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                              input logic [LW-1:0] idx);
    return AW'(LW'(base) + idx);
  endfunction

  wb_state_t             state;
  logic [LW-1:0]         len_q;
  logic [AW-1:0]         base_q;
  logic [LW-1:0]         acc_cnt;
  logic [LW-1:0]         ret_cnt;
  logic [LW-1:0]         start_len;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  wb_entry_t             push_entry;
  wb_entry_t             head_p0;
  logic                  pop_p0;
  logic                  vld_p1;
  logic [AW-1:0]         addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  assign start_len   = sat_len(vector_length_i, vmul_i);
  // Ready depends only on registered state, never on alu_valid_i or on a pop.
  assign alu_ready_o = (state == ACTIVE) && !fifo_full && (acc_cnt < len_q);
  assign accept      = alu_valid_i && alu_ready_o;
  assign pop_p0      = !fifo_empty && !BRAM_w_stall_i;
  assign ready_o     = (state == IDLE);
  assign done_o      = (state == DONE);

  assign push_entry = '{idx: acc_cnt, mask: alu_mask_i, data: alu_result_i};

  sync_fifo #(
    .WIDTH($bits(wb_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (push_entry),
    .pop   (pop_p0),
    .rdata (head_p0),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Control: instruction latch, accept/retire counters and phase sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      base_q  <= '0;
      acc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + LW'(1);
      if (pop_p0) ret_cnt <= ret_cnt + LW'(1);
      case (state)
        IDLE: begin
          if (start_i) begin
            len_q   <= start_len;
            base_q  <= reg_base(vd_address_i);
            acc_cnt <= '0;
            ret_cnt <= '0;
            state   <= (start_len == '0) ? DONE : ACTIVE;
          end
        end
        ACTIVE:  if (acc_cnt == len_q) state <= DRAIN;
        // ret_cnt reaches len in the pop cycle; its write beat is on the
        // outputs while this compare is true, so DONE follows the last beat.
        DRAIN:   if (ret_cnt == len_q) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: registered BRAM write beat from the popped FIFO head.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop_p0 && head_p0.mask;
      if (pop_p0) begin
        addr_p1 <= elem_addr(base_q, head_p0.idx);
        data_p1 <= head_p0.data;
      end
    end
  end

  assign BRAM_we_o        = vld_p1;
  assign BRAM_w_address_o = addr_p1;
  assign BRAM_wdata_o     = data_p1;

endmodule

// File: tb/tb_vrf_writeback_sequencer.sv
// Directed bench for vrf_writeback_sequencer with a queue-based reference model.
module tb_vrf_writeback_sequencer;

  localparam int VL = 1024;
  localparam int DW = 32;
  localparam int FD = 8;
  localparam int AW = 10;
  localparam int LW = 11;

  localparam int PH_IDLE   = 0;
  localparam int PH_ACTIVE = 1;
  localparam int PH_DRAIN  = 2;
  localparam int PH_DONE   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [4:0]    vd_address_i;
  logic [1:0]    vmul_i;
  logic [LW-1:0] vector_length_i;
  logic [DW-1:0] alu_result_i;
  logic          alu_mask_i;
  logic          alu_valid_i;
  logic          alu_ready_o;
  logic          BRAM_w_stall_i;
  logic [AW-1:0] BRAM_w_address_o;
  logic [DW-1:0] BRAM_wdata_o;
  logic          BRAM_we_o;
  logic          ready_o;
  logic          done_o;

  always #5 clk = ~clk;

  vrf_writeback_sequencer #(
    .VECTOR_LENGTH(VL),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .vd_address_i     (vd_address_i),
    .vmul_i           (vmul_i),
    .vector_length_i  (vector_length_i),
    .alu_result_i     (alu_result_i),
    .alu_mask_i       (alu_mask_i),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .BRAM_w_stall_i   (BRAM_w_stall_i),
    .BRAM_w_address_o (BRAM_w_address_o),
    .BRAM_wdata_o     (BRAM_wdata_o),
    .BRAM_we_o        (BRAM_we_o),
    .ready_o          (ready_o),
    .done_o           (done_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int          idx;
    bit          mask;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          m_phase = PH_IDLE;
  int          m_len = 0;
  int          m_base = 0;
  int          m_acc = 0;
  int          m_ret = 0;
  bit          m_we = 0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;

  function automatic bit model_alu_ready();
    return (m_phase == PH_ACTIVE) && (mq.size() < FD) && (m_acc < m_len);
  endfunction

  always @(posedge clk) begin : model
    bit    acc_ok;
    bit    pop_ok;
    int    acc_old;
    int    ret_old;
    int    cap;
    ment_t e;
    if (reset) begin
      mq.delete();
      m_phase = PH_IDLE;
      m_len = 0; m_base = 0; m_acc = 0; m_ret = 0;
      m_we = 0; m_addr = 0; m_data = '0;
    end else begin
      acc_ok  = alu_valid_i && model_alu_ready();
      pop_ok  = (mq.size() > 0) && !BRAM_w_stall_i;
      acc_old = m_acc;
      ret_old = m_ret;
      m_we = 0;
      if (pop_ok) begin
        e = mq.pop_front();
        m_we   = e.mask;
        m_addr = (m_base + e.idx) % VL;
        m_data = e.data;
        m_ret++;
      end
      if (acc_ok) begin
        e.idx  = m_acc;
        e.mask = alu_mask_i;
        e.data = alu_result_i;
        mq.push_back(e);
        m_acc++;
      end
      case (m_phase)
        PH_IDLE: if (start_i) begin
          cap    = 32 << vmul_i;
          m_len  = (int'(vector_length_i) < cap) ? int'(vector_length_i) : cap;
          m_base = (int'(vd_address_i) * 32) % VL;
          m_acc  = 0;
          m_ret  = 0;
          m_phase = (m_len == 0) ? PH_DONE : PH_ACTIVE;
        end
        PH_ACTIVE: if (acc_old == m_len) m_phase = PH_DRAIN;
        PH_DRAIN:  if (ret_old == m_len) m_phase = PH_DONE;
        default:   m_phase = PH_IDLE;
      endcase
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t log_q[$];
  int  acc_seen = 0;
  int  done_cnt = 0;
  int  first_acc = -1;
  int  first_we = -1;
  int  last_we_cyc = -1;
  int  done_cyc = -1;
  int  start_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    wr_t w;
    check("alu_ready_o", alu_ready_o, model_alu_ready());
    check("ready_o", ready_o, m_phase == PH_IDLE);
    check("done_o", done_o, m_phase == PH_DONE);
    check("BRAM_we_o", BRAM_we_o, m_we);
    check("BRAM_w_address_o", BRAM_w_address_o, m_addr);
    check("BRAM_wdata_o", BRAM_wdata_o, m_data);
    if (alu_valid_i && alu_ready_o) begin
      acc_seen++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (BRAM_we_o) begin
      w.addr = int'(BRAM_w_address_o);
      w.data = BRAM_wdata_o;
      log_q.push_back(w);
      if (first_we < 0) first_we = cyc;
      last_we_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start_i && ready_o) start_cyc = cyc;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] dval(input int tag, input int k);
    return {tag[7:0], 8'h5A, k[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    first_acc = -1;
    first_we = -1;
  endtask

  task automatic start_instr(input int vd, input int vmul, input int len);
    vd_address_i    = vd[4:0];
    vmul_i          = vmul[1:0];
    vector_length_i = len[LW-1:0];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic feed(input int n, input int tag, input logic [31:0] mask_off);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 3000) begin
      alu_valid_i  = 1'b1;
      alu_result_i = dval(tag, k);
      alu_mask_i   = !mask_off[k % 32];
      @(negedge clk);
      if (alu_ready_o) k++;
      tick();
      guard++;
    end
    alu_valid_i = 1'b0;
    check("feed_accepted", k, n);
  endtask

  task automatic wait_done(input string name, input int bound);
    int i = 0;
    bit seen = 0;
    while (i < bound && !seen) begin
      @(negedge clk);
      if (done_o) seen = 1;
      tick();
      i++;
    end
    check(name, seen, 1);
  endtask

  task automatic check_log_linear(input string name, input int n, input int base, input int tag);
    check({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check({name, "_addr"}, log_q[i].addr, (base + i) % VL);
      check({name, "_data"}, log_q[i].data, dval(tag, i));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0;
    int d0;
    int n0;
    int exp_idx[6];
    reset = 1'b1; start_i = 1'b0; vd_address_i = '0; vmul_i = '0;
    vector_length_i = '0; alu_result_i = '0; alu_mask_i = 1'b1;
    alu_valid_i = 1'b0; BRAM_w_stall_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_ready_o", ready_o, 1);
    check("rst_alu_ready_o", alu_ready_o, 0);
    check("rst_we", BRAM_we_o, 0);
    check("rst_addr", BRAM_w_address_o, 0);
    check("rst_wdata", BRAM_wdata_o, 0);
    check("rst_done", done_o, 0);
    tick();
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Basic write: v1, 32 elements
    clear_log(); d0 = done_cnt;
    start_instr(1, 0, 32);
    feed(32, 1, 32'h0);
    wait_done("basic_done", 200);
    check_log_linear("basic", 32, 32, 1);
    check("basic_latency", first_we - first_acc, 2);
    check("basic_done_after_last", done_cyc - last_we_cyc, 1);
    check("basic_done_count", done_cnt - d0, 1);

    // Grouping with wrap past v31
    clear_log();
    start_instr(30, 2, 128);
    feed(128, 2, 32'h0);
    wait_done("wrap_done", 400);
    check_log_linear("wrap", 128, 960, 2);

    // Oversized length clamps to one register
    clear_log();
    start_instr(3, 0, 200);
    feed(32, 3, 32'h0);
    wait_done("clamp_done", 200);
    check_log_linear("clamp", 32, 96, 3);

    // Backpressure: 20 stalled cycles fill the buffer exactly
    clear_log();
    BRAM_w_stall_i = 1'b1;
    start_instr(2, 0, 32);
    fork
      feed(32, 4, 32'h0);
      begin
        a0 = acc_seen;
        repeat (20) tick();
        check("bp_accepts", acc_seen - a0, FD);
        @(negedge clk);
        check("bp_ready_low", alu_ready_o, 0);
        tick();
        BRAM_w_stall_i = 1'b0;
      end
    join
    wait_done("bp_done", 200);
    check_log_linear("bp", 32, 64, 4);

    // Masked elements 2 and 5, then extra valids beyond len
    clear_log(); d0 = done_cnt; a0 = acc_seen;
    start_instr(4, 0, 8);
    feed(8, 5, 32'h24);
    alu_valid_i = 1'b1;
    repeat (12) tick();
    alu_valid_i = 1'b0;
    check("mask_extra_valid", acc_seen - a0, 8);
    check("mask_done_count", done_cnt - d0, 1);
    exp_idx = '{0, 1, 3, 4, 6, 7};
    check("mask_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("mask_addr", log_q[i].addr, 128 + exp_idx[i]);
      check("mask_data", log_q[i].data, dval(5, exp_idx[i]));
    end

    // Zero length completes without writes
    clear_log(); d0 = done_cnt;
    start_instr(7, 0, 0);
    repeat (3) tick();
    check("len0_done_count", done_cnt - d0, 1);
    check("len0_done_latency", done_cyc - start_cyc, 1);
    check("len0_writes", log_q.size(), 0);

    // start_i during ACTIVE is ignored
    clear_log();
    start_instr(5, 0, 16);
    fork
      feed(16, 6, 32'h0);
      begin
        repeat (4) tick();
        vd_address_i = 5'd9; vmul_i = 2'd3; vector_length_i = 11'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
      end
    join
    wait_done("restart_done", 200);
    check_log_linear("restart", 16, 160, 6);

    // Reset after 10 accepts abandons the instruction
    clear_log(); d0 = done_cnt;
    start_instr(6, 0, 32);
    feed(10, 7, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_we", BRAM_we_o, 0);
    check("rstmid_ready", ready_o, 1);
    check("rstmid_done", done_o, 0);
    check("rstmid_alu_ready", alu_ready_o, 0);
    tick();
    n0 = log_q.size();
    repeat (10) tick();
    check("rstmid_no_writes", log_q.size(), n0);
    check("rstmid_no_done", done_cnt - d0, 0);

    clear_log();
    start_instr(7, 0, 8);
    feed(8, 8, 32'h0);
    wait_done("after_rst_done", 100);
    check_log_linear("after_rst", 8, 224, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
